// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types and constants for the instruction fetch unit
//
// Contents:
//   XLEN             address/data width
//   DEFAULT_RESET_PC first fetch address after reset (default for the top parameter)
//   INSTR_NOP        canonical RISC-V nop (addi x0, x0, 0)
//   fetch_state_t    fetch sequencer states
//   fetch_entry_t    one buffered fetch: {pc, instr}
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO of fetch entries with flush
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the tail (ignored when full unless popping)
//   push_data    entry to write
//   pop          advance the head (ignored when empty)
//   flush        empty the FIFO; wins over push and pop in the same cycle
//   head         entry at the head (meaningful only when !empty)
//   count        number of valid entries, 0..DEPTH
//   full, empty  occupancy flags
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          push_en;
  logic          pop_en;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign pop_en  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_en = push & (~full | pop_en);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push_en && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner and instruction fetcher feeding decode
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   PCSrc, PCTarget    redirect from control/datapath, honoured only on a pop
//   imem_req/addr      fetch request to instruction memory, address held until ack
//   imem_ack/rdata     memory completion and returned word
//   instr_valid/ready  head-of-buffer handshake towards decode
//   Instr, PC, PCPlus4 head instruction, its address and address + 4
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int              XLEN       = riscv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     Instr,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] drop_target, drop_target_n;
  logic [XLEN-1:0] target;
  logic            pop, push, redirect, ack;
  logic [CW-1:0]   count, count_after;
  logic            full, empty;
  fetch_entry_t    head, push_entry;
  logic            unused_target_bits;

  assign unused_target_bits = ^{PCTarget[1:0], full};

  assign instr_valid = ~empty;
  assign pop         = instr_valid & instr_ready;
  assign redirect    = pop & PCSrc;
  assign target      = {PCTarget[XLEN-1:2], 2'b00};

  assign imem_req  = (state == FETCH) || (state == DROP);
  assign imem_addr = fetch_pc;
  // An ack with no request outstanding is noise and must never be consumed.
  assign ack       = imem_ack & imem_req;
  assign push      = (state == FETCH) & ack & ~redirect;

  // Occupancy after this cycle's push/pop; push never happens on a full FIFO.
  assign count_after = count + CW'(push) - CW'(pop);

  assign push_entry.pc    = fetch_pc;
  assign push_entry.instr = imem_rdata;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Head fields read as zero while nothing is valid, which also gives the reset values.
  assign Instr   = instr_valid ? head.instr : 32'h0;
  assign PC      = instr_valid ? head.pc : '0;
  assign PCPlus4 = PC + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      drop_target <= RESET_PC;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      drop_target <= drop_target_n;
    end
  end

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    drop_target_n = drop_target;
    case (state)
      IDLE: begin
        state_n = FETCH;
      end
      FETCH: begin
        if (ack) begin
          if (redirect) begin
            fetch_pc_n = target;
          end else begin
            fetch_pc_n = fetch_pc + XLEN'(4);
            if (count_after == DEPTH_C) state_n = STALL;
          end
        end else if (redirect) begin
          // The request in flight cannot be withdrawn; wait it out and discard it.
          drop_target_n = target;
          state_n       = DROP;
        end
      end
      DROP: begin
        if (redirect) drop_target_n = target;
        if (ack) begin
          fetch_pc_n = redirect ? target : drop_target;
          state_n    = FETCH;
        end
      end
      STALL: begin
        if (redirect) begin
          fetch_pc_n = target;
          state_n    = FETCH;
        end else if (count_after < DEPTH_C) begin
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
